// File: rtl/bitlogic_arbiter.sv
// Round-robin front end that shares one registered AND/OR/XOR/XNOR unit among NREQ requesters.
// One operation in flight; valid/ready handshakes on each request port and on the response port.
module bitlogic_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [2*NREQ-1:0]       req_op,
   input  logic [WIDTH*NREQ-1:0]   req_a,
   input  logic [WIDTH*NREQ-1:0]   req_b,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [IDW-1:0]          rsp_id,
   output logic [WIDTH-1:0]        rsp_data,
   output logic                    busy,
   output logic [15:0]             ops_done
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t             state_q, state_d;
   logic [IDW-1:0]     ptr_q;
   logic [1:0]         op_q;
   logic [WIDTH-1:0]   a_q, b_q;
   logic [WIDTH-1:0]   rspData_q;
   logic [IDW-1:0]     rspId_q;
   logic [15:0]        opsDone_q;

   logic               grantValid;
   logic [IDW-1:0]     grantIdx;
   logic               grantOk;
   logic [1:0]         selOp;
   logic [WIDTH-1:0]   selA, selB;
   logic [WIDTH-1:0]   result;

   // Scan downward so the candidate closest to ptr+1 is the last (winning) assignment.
   always_comb begin : pickWinner
      int cand;
      grantValid = 1'b0;
      grantIdx   = '0;
      cand       = 0;
      for (int k = NREQ; k >= 1; k--) begin
         cand = (int'(ptr_q) + k) % NREQ;
         if (req_valid[cand[IDW-1:0]]) begin
            grantValid = 1'b1;
            grantIdx   = cand[IDW-1:0];
         end
      end
   end

   assign grantOk   = grantValid && (state_q == IDLE) && !rst;
   assign req_ready = grantOk ? (NREQ'(1) << grantIdx) : '0;

   always_comb begin
      selOp = '0;
      selA  = '0;
      selB  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grantIdx == IDW'(i)) begin
            selOp = req_op[2*i +: 2];
            selA  = req_a[WIDTH*i +: WIDTH];
            selB  = req_b[WIDTH*i +: WIDTH];
         end
      end
   end

   always_comb begin
      case (op_q)
         2'b00:   result = a_q & b_q;
         2'b01:   result = a_q | b_q;
         2'b10:   result = a_q ^ b_q;
         default: result = ~(a_q ^ b_q);
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (grantOk) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // ptr doubles as the latched requester id: it only moves on a handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q     <= IDW'(NREQ-1);
         op_q      <= '0;
         a_q       <= '0;
         b_q       <= '0;
         rspData_q <= '0;
         rspId_q   <= '0;
         opsDone_q <= '0;
      end else begin
         if (grantOk) begin
            ptr_q <= grantIdx;
            op_q  <= selOp;
            a_q   <= selA;
            b_q   <= selB;
         end
         if (state_q == EXEC) begin
            rspData_q <= result;
            rspId_q   <= ptr_q;
         end
         if ((state_q == RESP) && rsp_ready) opsDone_q <= opsDone_q + 16'd1;
      end
   end

   assign rsp_valid = (state_q == RESP);
   assign busy      = (state_q != IDLE);
   assign rsp_data  = rspData_q;
   assign rsp_id    = rspId_q;
   assign ops_done  = opsDone_q;

endmodule
